fwd_scoreboard: RTL and testbench

FWD_SCOREBOARD -- requirements
Module: fwd_scoreboard

---
 rtl/fwd_scoreboard_if.sv | 26 ++
 rtl/fwd_scoreboard.sv | 106 ++++++++++
 tb/tb_fwd_scoreboard.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fwd_scoreboard_if.sv
// Issue-side bundle for the forwarding scoreboard: the instruction in ID
// and the stall answer returned to it.
interface fwd_scoreboard_if #(
    parameter int AW  = 4,
    parameter int NRD = 2
);
    logic              iss_vld;
    logic              iss_wr_en;
    logic [AW-1:0]     iss_wr_reg;
    logic              iss_load;
    logic [NRD-1:0]    iss_rd_en;
    logic [NRD*AW-1:0] iss_rd_reg;
    logic              stall;

    modport master (
        output iss_vld, iss_wr_en, iss_wr_reg, iss_load,
        output iss_rd_en, iss_rd_reg,
        input  stall
    );

    modport slave (
        input  iss_vld, iss_wr_en, iss_wr_reg, iss_load,
        input  iss_rd_en, iss_rd_reg,
        output stall
    );
endinterface

// File: rtl/fwd_scoreboard.sv
// Tracks in-flight destination writes past ID, raises load-use stalls and
// registers per-source forwarding selects for the instruction entering EX.
module fwd_scoreboard #(
    parameter int AW       = 4,
    parameter int NRD      = 2,
    parameter int DEPTH    = 3,
    parameter int ZERO_REG = 1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                hold,
    input  logic [DEPTH-1:0]                    flush,
    fwd_scoreboard_if.slave                     iss,
    output logic [NRD*$clog2(DEPTH+1)-1:0]      fwd_sel,
    output logic [15:0]                         stall_cnt
);
    localparam int SW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] v_q, v_d;
    logic [DEPTH-1:0] wr_q, wr_d;
    logic [DEPTH-1:0] ld_q, ld_d;
    logic [AW-1:0]    reg_q [DEPTH];
    logic [AW-1:0]    reg_d [DEPTH];
    logic [NRD*SW-1:0] sel_q, sel_d;
    logic [15:0]      stall_cnt_q, stall_cnt_d;

    logic [DEPTH-1:0][NRD-1:0] hit;
    logic load_use;
    logic stall;
    logic accept;

    // hit[k][p]: entry k produces the register read by enabled port p
    always_comb begin
        hit = '0;
        for (int k = 0; k < DEPTH; k++) begin
            for (int p = 0; p < NRD; p++) begin
                hit[k][p] = v_q[k] & wr_q[k] & iss.iss_rd_en[p]
                    & (reg_q[k] == iss.iss_rd_reg[p*AW +: AW])
                    & ~((ZERO_REG != 0)
                        && (iss.iss_rd_reg[p*AW +: AW] == '0));
            end
        end
    end

    assign load_use = ld_q[0] & (|hit[0]);
    assign stall    = rst_n & ~hold & iss.iss_vld & ~(|flush) & load_use;
    assign accept   = rst_n & ~hold & iss.iss_vld & ~stall & ~(|flush);
    assign iss.stall = stall;

    always_comb begin
        v_d         = v_q;
        wr_d        = wr_q;
        ld_d        = ld_q;
        reg_d       = reg_q;
        sel_d       = sel_q;
        stall_cnt_d = stall_cnt_q;
        if (!hold) begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                v_d[k]   = v_q[k-1] & ~flush[k-1];
                wr_d[k]  = wr_q[k-1];
                ld_d[k]  = ld_q[k-1];
                reg_d[k] = reg_q[k-1];
            end
            v_d[0]   = accept;
            wr_d[0]  = iss.iss_wr_en;
            ld_d[0]  = iss.iss_load;
            reg_d[0] = iss.iss_wr_reg;
            sel_d    = '0;
            // Oldest first so the youngest producer overwrites; the last
            // entry is skipped because the register file writes through.
            if (accept) begin
                for (int p = 0; p < NRD; p++) begin
                    for (int k = DEPTH - 2; k >= 0; k--) begin
                        if (hit[k][p] && !flush[k]) begin
                            sel_d[p*SW +: SW] = SW'(k + 1);
                        end
                    end
                end
            end
            if (stall && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_d = stall_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_q         <= '0;
            wr_q        <= '0;
            ld_q        <= '0;
            reg_q       <= '{default: '0};
            sel_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            v_q         <= v_d;
            wr_q        <= wr_d;
            ld_q        <= ld_d;
            reg_q       <= reg_d;
            sel_q       <= sel_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fwd_sel   = sel_q;
    assign stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_fwd_scoreboard.sv
// Scenario bench for fwd_scoreboard: default build plus a DEPTH=5/NRD=4
// build, expected selects queued at issue and checked at EX.
module tb_fwd_scoreboard;
    logic        clk;
    logic        rst_n;
    logic        hold_a, hold_b;
    logic [2:0]  flush_a;
    logic [4:0]  flush_b;
    logic [3:0]  fwd_a;
    logic [11:0] fwd_b;
    logic [15:0] cnt_a, cnt_b;

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0]  exp_qa [$];
    logic [11:0] exp_qb [$];
    logic [3:0]  ea;
    logic [11:0] eb;

    fwd_scoreboard_if #(.AW(4), .NRD(2)) ia();
    fwd_scoreboard_if #(.AW(4), .NRD(4)) ib();

    fwd_scoreboard dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .hold      (hold_a),
        .flush     (flush_a),
        .iss       (ia.slave),
        .fwd_sel   (fwd_a),
        .stall_cnt (cnt_a)
    );

    fwd_scoreboard #(.AW(4), .NRD(4), .DEPTH(5), .ZERO_REG(1)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .hold      (hold_b),
        .flush     (flush_b),
        .iss       (ib.slave),
        .fwd_sel   (fwd_b),
        .stall_cnt (cnt_b)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic vld, input logic we,
                       input logic [3:0] wr, input logic ld,
                       input logic [1:0] re, input logic [7:0] rr);
        ia.iss_vld    = vld;
        ia.iss_wr_en  = we;
        ia.iss_wr_reg = wr;
        ia.iss_load   = ld;
        ia.iss_rd_en  = re;
        ia.iss_rd_reg = rr;
    endtask

    task automatic idle(input int n);
        drv(0, 0, 4'd0, 0, 2'b00, 8'h00);
        repeat (n) tick();
    endtask

    task automatic test_reset();
        rst_n = 0;
        drv(1, 1, 4'd3, 1, 2'b11, {4'd3, 4'd3});
        #1;
        n_tests++;
        if (ia.stall !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_stall: got %b required 0", ia.stall);
        end
        repeat (2) tick();
        n_tests++;
        if (fwd_a !== 4'h0 || cnt_a !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_state: got sel %h cnt %h required 0 0",
                     fwd_a, cnt_a);
        end
        n_tests++;
        if (fwd_b !== 12'h0 || cnt_b !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_state_b: got sel %h cnt %h required 0 0",
                     fwd_b, cnt_b);
        end
        rst_n = 1;
        idle(3);
    endtask

    task automatic test_alu_fwd();
        drv(1, 1, 4'd3, 0, 2'b00, 8'h00);
        exp_qa.push_back(4'h0);
        tick();
        drv(1, 0, 4'd0, 0, 2'b01, {4'd0, 4'd3});
        #1;
        n_tests++;
        if (ia.stall !== 1'b0) begin
            n_fail++;
            $display("FAIL alu_stall: got %b required 0", ia.stall);
        end
        ea = exp_qa.pop_front();
        exp_qa.push_back(4'b0001);
        tick();
        ea = exp_qa.pop_front();
        n_tests++;
        if (fwd_a !== ea) begin
            n_fail++;
            $display("FAIL alu_fwd_mem: got %b required %b", fwd_a, ea);
        end
        idle(3);
    endtask

    task automatic test_load_use();
        drv(1, 1, 4'd5, 1, 2'b00, 8'h00);
        tick();
        drv(1, 0, 4'd0, 0, 2'b10, {4'd5, 4'd0});
        #1;
        n_tests++;
        if (ia.stall !== 1'b1) begin
            n_fail++;
            $display("FAIL lu_stall: got %b required 1", ia.stall);
        end
        exp_qa.push_back(4'h0);
        tick();
        ea = exp_qa.pop_front();
        n_tests++;
        if (fwd_a !== ea || cnt_a !== 16'd1) begin
            n_fail++;
            $display("FAIL lu_bubble: got sel %b cnt %0d required %b 1",
                     fwd_a, cnt_a, ea);
        end
        n_tests++;
        if (ia.stall !== 1'b0) begin
            n_fail++;
            $display("FAIL lu_one_cycle: got %b required 0", ia.stall);
        end
        exp_qa.push_back(4'b1000);
        tick();
        ea = exp_qa.pop_front();
        n_tests++;
        if (fwd_a !== ea || cnt_a !== 16'd1) begin
            n_fail++;
            $display("FAIL lu_fwd_wb: got sel %b cnt %0d required %b 1",
                     fwd_a, cnt_a, ea);
        end
        idle(3);
    endtask

    task automatic test_youngest();
        drv(1, 1, 4'd2, 0, 2'b00, 8'h00);
        tick();
        tick();
        drv(1, 0, 4'd0, 0, 2'b11, {4'd2, 4'd2});
        #1;
        n_tests++;
        if (ia.stall !== 1'b0) begin
            n_fail++;
            $display("FAIL young_stall: got %b required 0", ia.stall);
        end
        exp_qa.push_back(4'b0101);
        tick();
        ea = exp_qa.pop_front();
        n_tests++;
        if (fwd_a !== ea) begin
            n_fail++;
            $display("FAIL youngest_wins: got %b required %b", fwd_a, ea);
        end
        drv(1, 1, 4'd0, 1, 2'b00, 8'h00);
        tick();
        drv(1, 0, 4'd0, 0, 2'b11, 8'h00);
        #1;
        n_tests++;
        if (ia.stall !== 1'b0) begin
            n_fail++;
            $display("FAIL r0_stall: got %b required 0", ia.stall);
        end
        exp_qa.push_back(4'h0);
        tick();
        ea = exp_qa.pop_front();
        n_tests++;
        if (fwd_a !== ea) begin
            n_fail++;
            $display("FAIL r0_sel: got %b required %b", fwd_a, ea);
        end
        idle(3);
    endtask

    task automatic test_flush();
        drv(1, 1, 4'd7, 1, 2'b00, 8'h00);
        tick();
        drv(1, 0, 4'd0, 0, 2'b01, {4'd0, 4'd7});
        flush_a = 3'b001;
        #1;
        n_tests++;
        if (ia.stall !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_stall: got %b required 0", ia.stall);
        end
        exp_qa.push_back(4'h0);
        tick();
        flush_a = 3'b000;
        ea = exp_qa.pop_front();
        n_tests++;
        if (fwd_a !== ea || cnt_a !== 16'd1) begin
            n_fail++;
            $display("FAIL flush_sel: got sel %b cnt %0d required %b 1",
                     fwd_a, cnt_a, ea);
        end
        #1;
        n_tests++;
        if (ia.stall !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_e0_bubble: got %b required 0", ia.stall);
        end
        exp_qa.push_back(4'h0);
        tick();
        ea = exp_qa.pop_front();
        n_tests++;
        if (fwd_a !== ea) begin
            n_fail++;
            $display("FAIL flush_e1_invalid: got %b required %b", fwd_a, ea);
        end
        idle(3);
    endtask

    task automatic test_hold();
        drv(1, 1, 4'd8, 0, 2'b00, 8'h00);
        tick();
        drv(1, 1, 4'd9, 1, 2'b10, {4'd8, 4'd0});
        exp_qa.push_back(4'b0100);
        tick();
        ea = exp_qa.pop_front();
        n_tests++;
        if (fwd_a !== ea) begin
            n_fail++;
            $display("FAIL hold_pre_sel: got %b required %b", fwd_a, ea);
        end
        drv(1, 0, 4'd0, 0, 2'b01, {4'd0, 4'd9});
        hold_a = 1;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_tests++;
            if (ia.stall !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_stall[%0d]: got %b required 0",
                         i, ia.stall);
            end
            tick();
            n_tests++;
            if (fwd_a !== 4'b0100 || cnt_a !== 16'd1) begin
                n_fail++;
                $display("FAIL hold_frozen[%0d]: got sel %b cnt %0d required 0100 1",
                         i, fwd_a, cnt_a);
            end
        end
        hold_a = 0;
        #1;
        n_tests++;
        if (ia.stall !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_release_stall: got %b required 1", ia.stall);
        end
        exp_qa.push_back(4'h0);
        tick();
        ea = exp_qa.pop_front();
        n_tests++;
        if (fwd_a !== ea || cnt_a !== 16'd2 || ia.stall !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_release: got sel %b cnt %0d stall %b required %b 2 0",
                     fwd_a, cnt_a, ia.stall, ea);
        end
        exp_qa.push_back(4'b0010);
        tick();
        ea = exp_qa.pop_front();
        n_tests++;
        if (fwd_a !== ea) begin
            n_fail++;
            $display("FAIL hold_reaccept: got %b required %b", fwd_a, ea);
        end
        idle(3);
    endtask

    task automatic test_reset_mid_stall();
        drv(1, 1, 4'd4, 1, 2'b00, 8'h00);
        tick();
        drv(1, 0, 4'd0, 0, 2'b01, {4'd0, 4'd4});
        #1;
        n_tests++;
        if (ia.stall !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre_stall: got %b required 1", ia.stall);
        end
        rst_n = 0;
        #1;
        n_tests++;
        if (ia.stall !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_stall_low: got %b required 0", ia.stall);
        end
        tick();
        n_tests++;
        if (cnt_a !== 16'd0 || fwd_a !== 4'h0) begin
            n_fail++;
            $display("FAIL rst_clear: got cnt %0d sel %b required 0 0",
                     cnt_a, fwd_a);
        end
        rst_n = 1;
        #1;
        n_tests++;
        if (ia.stall !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_entries: got %b required 0", ia.stall);
        end
        exp_qa.push_back(4'h0);
        tick();
        ea = exp_qa.pop_front();
        n_tests++;
        if (fwd_a !== ea) begin
            n_fail++;
            $display("FAIL rst_reissue: got %b required %b", fwd_a, ea);
        end
        idle(3);
    endtask

    task automatic test_deep();
        ib.iss_vld    = 1;
        ib.iss_wr_en  = 1;
        ib.iss_wr_reg = 4'd6;
        ib.iss_load   = 0;
        ib.iss_rd_en  = 4'b0000;
        ib.iss_rd_reg = 16'h0000;
        tick();
        ib.iss_vld = 0;
        repeat (3) tick();
        ib.iss_vld    = 1;
        ib.iss_wr_en  = 0;
        ib.iss_rd_en  = 4'b0100;
        ib.iss_rd_reg = 16'h0600;
        exp_qb.push_back(12'h100);
        tick();
        eb = exp_qb.pop_front();
        n_tests++;
        if (fwd_b !== eb) begin
            n_fail++;
            $display("FAIL deep_e3: got %h required %h", fwd_b, eb);
        end
        ib.iss_rd_en  = 4'b1000;
        ib.iss_rd_reg = 16'h6000;
        exp_qb.push_back(12'h000);
        tick();
        eb = exp_qb.pop_front();
        n_tests++;
        if (fwd_b !== eb) begin
            n_fail++;
            $display("FAIL deep_e4: got %h required %h", fwd_b, eb);
        end
        ib.iss_vld = 0;
        tick();
        force dut_b.stall_cnt_q = 16'hFFFD;
        #1;
        release dut_b.stall_cnt_q;
        #1;
        n_tests++;
        if (cnt_b !== 16'hFFFD) begin
            n_fail++;
            $display("FAIL sat_preload: got %h required fffd", cnt_b);
        end
        ib.iss_vld    = 1;
        ib.iss_wr_en  = 1;
        ib.iss_wr_reg = 4'd1;
        ib.iss_load   = 1;
        ib.iss_rd_en  = 4'b0001;
        ib.iss_rd_reg = 16'h0001;
        repeat (2) tick();
        n_tests++;
        if (cnt_b !== 16'hFFFE) begin
            n_fail++;
            $display("FAIL sat_step: got %h required fffe", cnt_b);
        end
        repeat (10) tick();
        n_tests++;
        if (cnt_b !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL sat_hold: got %h required ffff", cnt_b);
        end
        ib.iss_vld = 0;
    endtask

    initial begin
        clk     = 0;
        rst_n   = 0;
        hold_a  = 0;
        hold_b  = 0;
        flush_a = '0;
        flush_b = '0;
        drv(0, 0, 4'd0, 0, 2'b00, 8'h00);
        ib.iss_vld    = 0;
        ib.iss_wr_en  = 0;
        ib.iss_wr_reg = '0;
        ib.iss_load   = 0;
        ib.iss_rd_en  = '0;
        ib.iss_rd_reg = '0;
        #1;
        test_reset();
        test_alu_fwd();
        test_load_use();
        test_youngest();
        test_flush();
        test_hold();
        test_reset_mid_stall();
        test_deep();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
